// File: rtl/mem_arbiter_if.sv
// Memory request/response channel shared by the caches and main memory.
// master drives requests and write data; slave returns ready and responses.
interface mem_arbiter_if #(
   parameter int ADDR_BITS = 28,
   parameter int DATA_BITS = 128
);
   logic                   req_valid;
   logic                   req_ready;
   logic [ADDR_BITS-1:0]   req_addr;
   logic                   req_rw;
   logic                   data_valid;
   logic                   data_ready;
   logic [DATA_BITS-1:0]   data_bits;
   logic [DATA_BITS/8-1:0] data_mask;
   logic                   resp_valid;
   logic [DATA_BITS-1:0]   resp_data;

   modport master (
      output req_valid, req_addr, req_rw,
      output data_valid, data_bits, data_mask,
      input  req_ready, data_ready,
      input  resp_valid, resp_data
   );

   modport slave (
      input  req_valid, req_addr, req_rw,
      input  data_valid, data_bits, data_mask,
      output req_ready, data_ready,
      output resp_valid, resp_data
   );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter between I-cache and D-cache onto one memory port.
// Read sources are logged in an in-order ID FIFO for response routing.
module mem_arbiter #(
   parameter int ADDR_BITS = 28,
   parameter int DATA_BITS = 128,
   parameter int MAX_OUTST = 4
) (
   input  logic          clk,
   input  logic          reset,
   mem_arbiter_if.slave  ic,
   mem_arbiter_if.slave  dc,
   mem_arbiter_if.master mem,
   output logic          err_orphan_resp
);
   localparam int PW = $clog2(MAX_OUTST);

   typedef enum logic [1:0] {IDLE, ADDR, WDATA} state_t;

   state_t                 state;
   logic                   gnt;
   logic                   rr_last;
   logic [MAX_OUTST-1:0]   id_q;
   logic [PW-1:0]          wr_ptr;
   logic [PW-1:0]          rd_ptr;
   logic [PW:0]            count;

   logic                   sel_valid;
   logic                   sel_rw;
   logic [ADDR_BITS-1:0]   sel_addr;
   logic                   sel_dvalid;
   logic [DATA_BITS-1:0]   sel_bits;
   logic [DATA_BITS/8-1:0] sel_mask;
   logic                   in_addr;
   logic                   in_data;
   logic                   full;
   logic                   hold;
   logic                   req_hs;
   logic                   data_hs;
   logic                   push;
   logic                   pop;
   logic                   head;

   assign sel_valid  = gnt ? dc.req_valid  : ic.req_valid;
   assign sel_rw     = gnt ? dc.req_rw     : ic.req_rw;
   assign sel_addr   = gnt ? dc.req_addr   : ic.req_addr;
   assign sel_dvalid = gnt ? dc.data_valid : ic.data_valid;
   assign sel_bits   = gnt ? dc.data_bits  : ic.data_bits;
   assign sel_mask   = gnt ? dc.data_mask  : ic.data_mask;

   assign in_addr = (state == ADDR);
   assign in_data = (state == ADDR) || (state == WDATA);

   // Full uses the pre-pop count so a same-cycle pop never widens the window.
   assign full = (count == (PW+1)'(MAX_OUTST));
   assign hold = !sel_rw && full;

   assign mem.req_valid  = in_addr && sel_valid && !hold;
   assign mem.req_addr   = sel_addr;
   assign mem.req_rw     = sel_rw;
   assign req_hs         = mem.req_valid && mem.req_ready;
   assign ic.req_ready   = req_hs && !gnt;
   assign dc.req_ready   = req_hs && gnt;

   assign mem.data_valid = in_data && sel_dvalid;
   assign mem.data_bits  = sel_bits;
   assign mem.data_mask  = sel_mask;
   assign data_hs        = mem.data_valid && mem.data_ready;
   assign ic.data_ready  = in_data && !gnt && mem.data_ready;
   assign dc.data_ready  = in_data && gnt && mem.data_ready;

   assign push = req_hs && !sel_rw;
   assign pop  = mem.resp_valid && (count != '0);
   assign head = id_q[rd_ptr];

   assign ic.resp_valid = pop && !head;
   assign dc.resp_valid = pop && head;
   assign ic.resp_data  = mem.resp_data;
   assign dc.resp_data  = mem.resp_data;

   // Grant FSM: arbitrate in IDLE, address phase, optional locked data phase.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         gnt     <= 1'b0;
         rr_last <= 1'b1;
      end else begin
         unique case (state)
            IDLE: begin
               if (ic.req_valid || dc.req_valid) begin
                  gnt   <= (ic.req_valid && dc.req_valid) ? !rr_last : dc.req_valid;
                  state <= ADDR;
               end
            end
            ADDR: begin
               if (!sel_valid) begin
                  state <= IDLE;
               end else if (req_hs) begin
                  rr_last <= gnt;
                  state   <= (!sel_rw || data_hs) ? IDLE : WDATA;
               end
            end
            WDATA: begin
               if (data_hs) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // In-order ID FIFO of read sources.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         id_q   <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            id_q[wr_ptr] <= gnt;
            wr_ptr       <= wr_ptr + PW'(1);
         end
         if (pop) rd_ptr <= rd_ptr + PW'(1);
         unique case ({push, pop})
            2'b10:   count <= count + (PW+1)'(1);
            2'b01:   count <= count - (PW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   // Sticky flag for a response beat with no outstanding read.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) err_orphan_resp <= 1'b0;
      else if (mem.resp_valid && count == '0) err_orphan_resp <= 1'b1;
   end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a queue-based response/ownership model.
// Inputs change 1ns after posedge; outputs are sampled on negedge.
module tb_mem_arbiter;
   logic clk = 1'b0;
   logic reset;
   logic err;
   int   total = 0;
   int   bad   = 0;

   bit   expq[$];
   bit   glog[$];
   bit   err_m;

   mem_arbiter_if ic_if ();
   mem_arbiter_if dc_if ();
   mem_arbiter_if mem_if ();

   mem_arbiter dut (
      .clk(clk),
      .reset(reset),
      .ic(ic_if),
      .dc(dc_if),
      .mem(mem_if),
      .err_orphan_resp(err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [143:0] a, input logic [143:0] e);
      total++;
      if (a !== e) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h", nm, a, e);
      end
   endtask

   // Reference model: outstanding read sources in order, sticky error.
   always @(negedge clk) begin : model
      bit id;
      if (reset) begin
         expq.delete();
         err_m = 1'b0;
         chk("rst_outs", {mem_if.req_valid, mem_if.data_valid,
             ic_if.req_ready, dc_if.req_ready, ic_if.data_ready,
             dc_if.data_ready, ic_if.resp_valid, dc_if.resp_valid}, 0);
      end else begin
         chk("err", err, err_m);
         chk("two_ready", ic_if.req_ready & dc_if.req_ready, 0);
         chk("two_dready", ic_if.data_ready & dc_if.data_ready, 0);
         if (ic_if.req_ready)
            chk("ic_fwd", {mem_if.req_valid, mem_if.req_rw, mem_if.req_addr},
                {1'b1, ic_if.req_rw, ic_if.req_addr});
         if (dc_if.req_ready)
            chk("dc_fwd", {mem_if.req_valid, mem_if.req_rw, mem_if.req_addr},
                {1'b1, dc_if.req_rw, dc_if.req_addr});
         if (mem_if.req_valid && mem_if.req_ready)
            chk("hs_owner", ic_if.req_ready | dc_if.req_ready, 1);
         chk("full_hold", mem_if.req_valid && !mem_if.req_rw && expq.size() == 4, 0);
         if (ic_if.data_ready && ic_if.data_valid)
            chk("ic_dfwd", {mem_if.data_valid, mem_if.data_mask, mem_if.data_bits},
                {1'b1, ic_if.data_mask, ic_if.data_bits});
         if (dc_if.data_ready && dc_if.data_valid)
            chk("dc_dfwd", {mem_if.data_valid, mem_if.data_mask, mem_if.data_bits},
                {1'b1, dc_if.data_mask, dc_if.data_bits});
         if (mem_if.resp_valid) begin
            if (expq.size() == 0) begin
               chk("orphan_route", {ic_if.resp_valid, dc_if.resp_valid}, 0);
               err_m = 1'b1;
            end else begin
               id = expq.pop_front();
               chk("route", {ic_if.resp_valid, dc_if.resp_valid}, id ? 2'b01 : 2'b10);
               chk("rdata", id ? dc_if.resp_data : ic_if.resp_data, mem_if.resp_data);
            end
         end else begin
            chk("no_resp", {ic_if.resp_valid, dc_if.resp_valid}, 0);
         end
         if (ic_if.req_valid && ic_if.req_ready) begin
            glog.push_back(1'b0);
            if (!ic_if.req_rw) expq.push_back(1'b0);
         end
         if (dc_if.req_valid && dc_if.req_ready) begin
            glog.push_back(1'b1);
            if (!dc_if.req_rw) expq.push_back(1'b1);
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      cyc();
      cyc();
      reset = 1'b0;
   endtask

   // Drop each cache's valids once its handshake completes.
   task automatic serve(input int budget);
      bit di, dd, ddi, ddd;
      for (int i = 0; i < budget; i++) begin
         if (!ic_if.req_valid && !dc_if.req_valid &&
             !ic_if.data_valid && !dc_if.data_valid) break;
         @(negedge clk);
         di  = ic_if.req_valid & ic_if.req_ready;
         dd  = dc_if.req_valid & dc_if.req_ready;
         ddi = ic_if.data_valid & ic_if.data_ready;
         ddd = dc_if.data_valid & dc_if.data_ready;
         cyc();
         if (di)  ic_if.req_valid  = 1'b0;
         if (dd)  dc_if.req_valid  = 1'b0;
         if (ddi) ic_if.data_valid = 1'b0;
         if (ddd) dc_if.data_valid = 1'b0;
      end
      chk("serve_timeout", {ic_if.req_valid, dc_if.req_valid,
          ic_if.data_valid, dc_if.data_valid}, 0);
   endtask

   task automatic respond_one(input logic [127:0] d, input bit exp_dc);
      mem_if.resp_valid = 1'b1;
      mem_if.resp_data  = d;
      @(negedge clk);
      chk("r_ic", ic_if.resp_valid, !exp_dc);
      chk("r_dc", dc_if.resp_valid, exp_dc);
      chk("r_data", ic_if.resp_data, d);
      cyc();
      mem_if.resp_valid = 1'b0;
   endtask

   task automatic check_order(input string nm, input logic [7:0] e, input int n);
      chk({nm, "_n"}, glog.size(), n);
      for (int i = 0; i < n && i < glog.size(); i++) chk(nm, glog[i], e[i]);
      glog.delete();
   endtask

   task automatic rd(input bit dcm, input logic [27:0] a);
      if (dcm) begin
         dc_if.req_valid = 1'b1; dc_if.req_rw = 1'b0; dc_if.req_addr = a;
      end else begin
         ic_if.req_valid = 1'b1; ic_if.req_rw = 1'b0; ic_if.req_addr = a;
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      reset = 1'b1;
      {ic_if.req_valid, ic_if.req_rw, ic_if.data_valid} = '0;
      {dc_if.req_valid, dc_if.req_rw, dc_if.data_valid} = '0;
      ic_if.req_addr = '0; dc_if.req_addr = '0;
      ic_if.data_bits = '0; dc_if.data_bits = '0;
      ic_if.data_mask = '0; dc_if.data_mask = '0;
      mem_if.req_ready = 1'b0; mem_if.data_ready = 1'b0;
      mem_if.resp_valid = 1'b0; mem_if.resp_data = '0;
      cyc();
      @(negedge clk);
      chk("reset_err", err, 0);
      chk("reset_mem", {mem_if.req_valid, mem_if.data_valid}, 0);
      cyc();
      reset = 1'b0;
      mem_if.req_ready = 1'b1;
      mem_if.data_ready = 1'b1;

      // 1: single IC read
      glog.delete();
      rd(0, 28'h0000010);
      @(negedge clk);
      chk("t1_latency", mem_if.req_valid, 0);
      cyc();
      serve(10);
      check_order("t1_order", 8'b0, 1);
      cyc();
      cyc();
      respond_one(128'hD00D_0001, 0);
      @(negedge clk);
      chk("t1_resp_off", {ic_if.resp_valid, dc_if.resp_valid}, 0);
      cyc();

      // 2: ties from reset, then after an IC-only grant
      do_reset();
      rd(0, 28'h20);
      rd(1, 28'h30);
      cyc();
      serve(10);
      check_order("t2_tie0", 8'b10, 2);
      respond_one(128'hAAAA_0000, 0);
      respond_one(128'hBBBB_0001, 1);
      rd(0, 28'h24);
      cyc();
      serve(10);
      glog.delete();
      rd(0, 28'h28);
      rd(1, 28'h38);
      cyc();
      serve(10);
      check_order("t2_tie1", 8'b01, 2);
      respond_one(128'h11, 0);
      respond_one(128'h22, 1);
      respond_one(128'h33, 0);

      // 3: DC write locks data path while IC waits
      mem_if.data_ready = 1'b0;
      dc_if.req_valid = 1'b1; dc_if.req_rw = 1'b1; dc_if.req_addr = 28'h40;
      dc_if.data_valid = 1'b1;
      dc_if.data_bits = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_0F0F_F0F0;
      dc_if.data_mask = 16'hF0F0;
      rd(0, 28'h50);
      @(negedge clk);
      chk("t3_idle", mem_if.req_valid, 0);
      cyc();
      @(negedge clk);
      chk("t3_gnt", {dc_if.req_ready, ic_if.req_ready, dc_if.data_ready}, 3'b100);
      cyc();
      dc_if.req_valid = 1'b0;
      repeat (2) begin
         @(negedge clk);
         chk("t3_wdata", {ic_if.req_ready, mem_if.req_valid, mem_if.data_valid}, 3'b001);
         chk("t3_bits", mem_if.data_bits, 128'hDEAD_BEEF_0123_4567_89AB_CDEF_0F0F_F0F0);
         cyc();
      end
      mem_if.data_ready = 1'b1;
      @(negedge clk);
      chk("t3_dhs", {dc_if.data_ready, ic_if.data_ready}, 2'b10);
      cyc();
      dc_if.data_valid = 1'b0;
      serve(10);
      check_order("t3_order", 8'b01, 2);
      respond_one(128'h3333, 0);

      // 4: FIFO full gating and same-cycle push/pop
      for (int k = 0; k < 4; k++) begin
         rd(0, 28'h100 + 28'(k));
         cyc();
         serve(10);
      end
      check_order("t4_four", 8'b0, 4);
      rd(0, 28'h200);
      repeat (3) begin
         @(negedge clk);
         chk("t4_hold", {mem_if.req_valid, ic_if.req_ready}, 0);
         cyc();
      end
      respond_one(128'h4000, 0);
      @(negedge clk);
      chk("t4_accept", mem_if.req_valid, 1);
      cyc();
      ic_if.req_valid = 1'b0;
      respond_one(128'h4001, 0);
      rd(0, 28'h300);
      cyc();
      mem_if.resp_valid = 1'b1;
      mem_if.resp_data = 128'h4002;
      @(negedge clk);
      chk("t4_pushpop", {mem_if.req_valid, ic_if.resp_valid}, 2'b11);
      cyc();
      ic_if.req_valid = 1'b0;
      mem_if.resp_valid = 1'b0;
      rd(0, 28'h400);
      cyc();
      serve(10);
      rd(0, 28'h500);
      cyc();
      repeat (2) begin
         @(negedge clk);
         chk("t4_hold2", mem_if.req_valid, 0);
         cyc();
      end
      respond_one(128'h4003, 0);
      serve(10);
      for (int k = 0; k < 4; k++) respond_one(128'h4100 + 128'(k), 0);
      glog.delete();

      // 5: orphan response
      mem_if.resp_valid = 1'b1;
      mem_if.resp_data = 128'h5555;
      @(negedge clk);
      chk("t5_route", {ic_if.resp_valid, dc_if.resp_valid, err}, 0);
      cyc();
      mem_if.resp_valid = 1'b0;
      repeat (3) begin
         @(negedge clk);
         chk("t5_sticky", err, 1);
         cyc();
      end

      // 6: reset during WDATA with reads outstanding
      do_reset();
      @(negedge clk);
      chk("t6_err_clr", err, 0);
      cyc();
      rd(0, 28'h600);
      cyc();
      serve(10);
      rd(0, 28'h601);
      cyc();
      serve(10);
      mem_if.data_ready = 1'b0;
      dc_if.req_valid = 1'b1; dc_if.req_rw = 1'b1; dc_if.req_addr = 28'h700;
      dc_if.data_valid = 1'b1;
      cyc();
      @(negedge clk);
      chk("t6_addr", dc_if.req_ready, 1);
      cyc();
      dc_if.req_valid = 1'b0;
      @(negedge clk);
      chk("t6_wdata", mem_if.data_valid, 1);
      #2;
      reset = 1'b1;
      #1;
      chk("t6_async", {mem_if.req_valid, mem_if.data_valid, ic_if.req_ready,
          dc_if.req_ready, ic_if.data_ready, dc_if.data_ready}, 0);
      dc_if.data_valid = 1'b0;
      mem_if.data_ready = 1'b1;
      cyc();
      cyc();
      reset = 1'b0;
      mem_if.resp_valid = 1'b1;
      @(negedge clk);
      chk("t6_orphan", {ic_if.resp_valid, dc_if.resp_valid}, 0);
      cyc();
      mem_if.resp_valid = 1'b0;
      @(negedge clk);
      chk("t6_err", err, 1);
      cyc();
      glog.delete();
      rd(0, 28'h800);
      cyc();
      serve(10);
      check_order("t6_order", 8'b0, 1);
      respond_one(128'h6666, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
